sae_stream_ctrl: RTL and testbench
==================================

Name: sae_stream_ctrl

Overview:
- Host-side initiator for the single-byte SAE engine: drives the engine's mode/input_data/input_key/valid_input and collects output_data/output_ready.
- Converts a ready/valid byte stream into one engine transaction per byte, then returns results on a ready/valid stream.
- Sits between the message buffer or DMA and the SAE engine; supports key-pair generation, encryption and decryption of whole messages.

Parameters:
DEPTH, 4, input FIFO entries (power of 2, ≥2)
TIMEOUT, 8, max cycles waiting for engine output_ready before aborting

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
cfg_mode  in  2  01 keygen, 10 encrypt, 11 decrypt, 00 none
cfg_key  in  8  secret key (01/11) or public key (10)
cfg_start  in  1  one-cycle pulse; latches cfg_mode/cfg_key; ignored unless busy=0
s_data  in  8  input byte (plaintext/ciphertext)
s_valid  in  1  s_data valid
s_last  in  1  final byte of message
s_ready  out  1  FIFO not full
m_data  out  8  result byte
m_valid  out  1  result valid
m_last  out  1  final result of message
m_ready  in  1  sink accepts result
sae_mode  out  2  to engine mode
sae_data  out  8  to engine input_data
sae_key  out  8  to engine input_key
sae_valid  out  1  to engine valid_input
sae_out_data  in  8  from engine output_data
sae_out_ready  in  1  from engine output_ready
sae_err  in  1  from engine err_invalid_seckey
busy  out  1  operation in progress
err_key  out  1  sticky: secret key rejected
err_timeout  out  1  sticky: engine did not respond

Behaviour:
- Reset: all outputs 0 except s_ready=1; FSM IDLE; FIFO empty; error flags cleared. Reset mid-operation aborts immediately, and the FIFO is flushed.
- Input FIFO accepts a byte when s_valid&s_ready, in both IDLE and busy. It stores {s_last,s_data}. s_ready=0 when DEPTH entries are held. A simultaneous push and pop is allowed when full.
- FSM states: IDLE, CHECK, ISSUE, GUARD, WAIT, OUT.
- IDLE: on cfg_start with cfg_mode≠00, latch mode/key, clear err_key/err_timeout, busy=1, go CHECK. cfg_mode=00 is ignored.
- CHECK (1 cycle): for mode 01/11, if key==0 or key>222, set err_key and return to IDLE (busy=0) without asserting sae_valid. Otherwise go to ISSUE. Mode 10 skips the check. Mode 01 proceeds with no data; modes 10/11 stay in CHECK until the FIFO is non-empty.
- ISSUE (1 cycle): sae_valid=1 and sae_data=FIFO head (00 for mode 01). Pop the FIFO, remember the last bit (1 for mode 01).
- sae_mode and sae_key are held at the latched values for the whole operation and are 0 in IDLE. sae_data is held until the next ISSUE.
- GUARD (1 cycle): sae_valid=0. sae_out_ready is ignored here because the engine's output_ready is level and may still reflect the previous byte.
- WAIT: sae_valid=0, counter increments per cycle.
  - When sae_out_ready=1, capture sae_out_data into m_data with the last bit and go OUT.
  - When sae_err=1, set err_key, flush the FIFO and go IDLE.
  - When the counter reaches TIMEOUT, set err_timeout, flush the FIFO and go IDLE.
- OUT: m_valid=1 until m_ready. On handshake: if last, go IDLE with busy=0 in the next cycle; else go CHECK for the next byte.
- Latency: ISSUE to m_valid is 3 cycles with a nominal engine. Throughput is 1 byte per 4 cycles with m_ready held high.
- m_data and m_last are stable while m_valid=1 and m_ready=0.
- cfg_start while busy=1 is ignored. Bytes arriving after last stay queued for the next operation.

Test Plan:
- Keygen: cfg_mode=01, cfg_key=100 → one result m_data=123, m_last=1, sae_valid pulsed exactly once, busy returns 0.
- Encrypt: cfg_mode=10, key=123, bytes 10,200,150(last) → results 133,100,50, m_last only on 50.
- Decrypt round-trip: cfg_mode=11, key=100, bytes 133,100,50(last) → results 10,200,150. Run with the FIFO filled to DEPTH beforehand; s_ready must be 0 when full.
- Invalid key: cfg_mode=11, key=0 (and separately key=223) → err_key=1, sae_valid never asserted, busy=0 within 2 cycles.
- Backpressure and timeout:
  - m_ready=0 for 5 cycles mid-message → m_data held stable, no new ISSUE.
  - Engine model never raising sae_out_ready → err_timeout after 8 WAIT cycles, FIFO empty.
- Reset mid-WAIT → all outputs at reset values on the next sample, and the FIFO is empty.

Source files
------------

// File: rtl/sae_stream_ctrl.sv
// sae_stream_ctrl: host-side initiator for the single-byte SAE engine.
// Buffers an incoming byte stream in a small FIFO, runs one engine
// transaction per byte, and returns the results on a ready/valid stream.
module sae_stream_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] cfg_key,
    input  logic       cfg_start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic [1:0] sae_mode,
    output logic [7:0] sae_data,
    output logic [7:0] sae_key,
    output logic       sae_valid,
    input  logic [7:0] sae_out_data,
    input  logic       sae_out_ready,
    input  logic       sae_err,
    output logic       busy,
    output logic       err_key,
    output logic       err_timeout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_KEYGEN = 2'b01;
    localparam logic [1:0] MODE_ENC    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Secret keys must lie in 1..222; the public key used for encryption is not checked.
    function automatic logic key_invalid(input logic [1:0] mode, input logic [7:0] key);
        return (mode != MODE_ENC) && ((key == 8'd0) || (key > 8'd222));
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [7:0]     key_q, key_d;
    logic           last_q, last_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic [7:0]     sae_data_q, sae_data_d;
    logic           sae_valid_q, sae_valid_d;
    logic [7:0]     m_data_q, m_data_d;
    logic           m_last_q, m_last_d;
    logic           m_valid_q, m_valid_d;
    logic           busy_q, busy_d;
    logic           err_key_q, err_key_d;
    logic           err_timeout_q, err_timeout_d;
    logic           s_ready_q, s_ready_d;

    logic [8:0]     mem_q [DEPTH];
    logic [8:0]     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           push_s;
    logic           pop_s;
    logic           flush_s;
    logic [8:0]     head_s;
    logic           fifo_empty_s;

    assign push_s       = s_valid & s_ready_q;
    assign head_s       = mem_q[rd_ptr_q];
    assign fifo_empty_s = (count_q == CW'(0));

    // Next-state and output decode for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        key_d         = key_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        sae_data_d    = sae_data_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        err_key_d     = err_key_q;
        err_timeout_d = err_timeout_q;
        pop_s         = 1'b0;
        flush_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && (cfg_mode != MODE_NONE)) begin
                    mode_d        = cfg_mode;
                    key_d         = cfg_key;
                    err_key_d     = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (key_invalid(mode_q, key_q)) begin
                    err_key_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (mode_q == MODE_KEYGEN) begin
                    sae_data_d = 8'h00;
                    state_d    = ST_ISSUE;
                end else if (!fifo_empty_s) begin
                    sae_data_d = head_s[7:0];
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_ISSUE: begin
                pop_s   = (mode_q != MODE_KEYGEN);
                last_d  = (mode_q == MODE_KEYGEN) ? 1'b1 : head_s[8];
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                // The engine's ready is a level and may still show the previous result.
                cnt_d   = TW'(0);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sae_out_ready) begin
                    m_data_d = sae_out_data;
                    m_last_d = last_q;
                    state_d  = ST_OUT;
                end else if (sae_err) begin
                    err_key_d = 1'b1;
                    flush_s   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    flush_s       = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_OUT: begin
                if (!m_ready) begin
                    state_d = ST_OUT;
                end else if (m_last_q) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty_s) begin
                    // Key already validated: go straight to the next byte for 4-cycle throughput.
                    sae_data_d = head_s[7:0];
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Mode and key drive the engine directly, so they read as zero whenever idle.
        mode_d      = (state_d == ST_IDLE) ? 2'b00 : mode_d;
        key_d       = (state_d == ST_IDLE) ? 8'h00 : key_d;
        sae_valid_d = (state_d == ST_ISSUE);
        m_valid_d   = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    // Next-state of the input FIFO; a flush keeps only a byte accepted in the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {s_last, s_data};
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        if (flush_s) begin
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + AW'(push_s);
            count_d  = CW'(push_s);
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop_s);
            wr_ptr_d = wr_ptr_q + AW'(push_s);
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
        end

        // A full FIFO still accepts a byte in the cycle its head is being popped.
        s_ready_d = (count_d != CW'(DEPTH)) ||
                    ((state_d == ST_ISSUE) && (mode_d != MODE_KEYGEN));
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= 2'b00;
            key_q         <= 8'h00;
            last_q        <= 1'b0;
            cnt_q         <= TW'(0);
            sae_data_q    <= 8'h00;
            sae_valid_q   <= 1'b0;
            m_data_q      <= 8'h00;
            m_last_q      <= 1'b0;
            m_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_key_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            key_q         <= key_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            sae_data_q    <= sae_data_d;
            sae_valid_q   <= sae_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            m_valid_q     <= m_valid_d;
            busy_q        <= busy_d;
            err_key_q     <= err_key_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // FIFO storage, pointers and the registered ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
            wr_ptr_q  <= AW'(0);
            rd_ptr_q  <= AW'(0);
            count_q   <= CW'(0);
            s_ready_q <= 1'b1;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign sae_mode    = mode_q;
    assign sae_key     = key_q;
    assign sae_data    = sae_data_q;
    assign sae_valid   = sae_valid_q;
    assign busy        = busy_q;
    assign err_key     = err_key_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sae_stream_ctrl.sv
// Testbench for sae_stream_ctrl: table-driven operations plus hand-written
// corner sequences, with a behavioural SAE engine and an output scoreboard.
module tb_sae_stream_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int NV      = 9;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_key;
    logic       cfg_start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic [1:0] sae_mode;
    logic [7:0] sae_data;
    logic [7:0] sae_key;
    logic       sae_valid;
    logic [7:0] sae_out_data;
    logic       sae_out_ready;
    logic       sae_err;
    logic       busy;
    logic       err_key;
    logic       err_timeout;

    always #5 clk = ~clk;

    sae_stream_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_mode(cfg_mode), .cfg_key(cfg_key), .cfg_start(cfg_start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .sae_mode(sae_mode), .sae_data(sae_data), .sae_key(sae_key), .sae_valid(sae_valid),
        .sae_out_data(sae_out_data), .sae_out_ready(sae_out_ready), .sae_err(sae_err),
        .busy(busy), .err_key(err_key), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] key;
        int         n;
        logic [7:0] din  [3];
        logic [7:0] dout [3];
        bit         bad;
    } vec_t;

    vec_t       tbl [NV];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         n_issue = 0;
    logic [8:0] exp_q [$];
    logic [1:0] cur_mode = 2'b00;
    logic [7:0] cur_key  = 8'h00;
    bit         eng_mute = 1'b0;
    bit         eng_err_mode = 1'b0;
    logic       eng_pend;
    logic [7:0] eng_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine arithmetic: pk = 223 - sk; enc c = (p + pk) mod 223; dec p = (c + sk) mod 223.
    function automatic logic [7:0] eng_fn(input logic [1:0] md, input logic [7:0] d, input logic [7:0] k);
        int r;
        if (md == 2'b01) r = 223 - int'(k);
        else             r = (int'(d) + int'(k)) % 223;
        return 8'(r);
    endfunction

    // Engine model: result and level-high ready appear two edges after valid_input.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sae_out_ready <= 1'b0;
            sae_out_data  <= 8'h00;
            sae_err       <= 1'b0;
            eng_pend      <= 1'b0;
            eng_res       <= 8'h00;
        end else if (sae_valid) begin
            sae_out_ready <= 1'b0;
            sae_err       <= 1'b0;
            eng_pend      <= 1'b1;
            eng_res       <= eng_fn(sae_mode, sae_data, sae_key);
        end else if (eng_pend) begin
            eng_pend     <= 1'b0;
            sae_out_data <= eng_res;
            if (eng_err_mode) sae_err <= 1'b1;
            else if (!eng_mute) sae_out_ready <= 1'b1;
        end
    end

    // Issue counter and scoreboard; sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n && sae_valid) begin
            n_issue <= n_issue + 1;
            check("issue_mode", sae_mode, cur_mode);
            check("issue_key", sae_key, cur_key);
            if (cur_mode == 2'b01) check("issue_keygen_data", sae_data, 8'h00);
        end
        if (reset_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h expected none", m_data);
            end else begin
                check("out_data", m_data, exp_q[0][7:0]);
                check("out_last", m_last, exp_q[0][8]);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic set_vec(input int i, input logic [1:0] md, input logic [7:0] k, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input bit bad);
        tbl[i].mode = md; tbl[i].key = k; tbl[i].n = n; tbl[i].bad = bad;
        tbl[i].din[0] = d0; tbl[i].din[1] = d1; tbl[i].din[2] = d2;
        tbl[i].dout[0] = e0; tbl[i].dout[1] = e1; tbl[i].dout[2] = e2;
    endtask

    task automatic start_op(input logic [1:0] md, input logic [7:0] k);
        @(posedge clk); #1;
        cfg_mode = md; cfg_key = k; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_mode = 2'b00; cfg_key = 8'h00;
    endtask

    task automatic feed_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        @(posedge clk); #1;
        s_data = d; s_last = l; s_valid = 1'b1;
        while (t < 64) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            t++;
        end
        s_valid = 1'b0;
        if (t >= 64) check("feed_timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_sae_valid(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!sae_valid && t < 40);
        check(name, sae_valid, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        base = n_issue;
        cur_mode = v.mode;
        cur_key  = v.key;
        if (v.bad) begin
            start_op(v.mode, v.key);
            @(posedge clk); #1;
            check($sformatf("vec%0d_bad_busy", idx), busy, 1'b0);
            check($sformatf("vec%0d_bad_errkey", idx), err_key, 1'b1);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("vec%0d_bad_noissue", idx), n_issue - base, 0);
        end else begin
            if (v.n == 0) exp_q.push_back({1'b1, v.dout[0]});
            start_op(v.mode, v.key);
            for (int i = 0; i < v.n; i++) begin
                exp_q.push_back({(i == v.n - 1), v.dout[i]});
                feed_byte(v.din[i], (i == v.n - 1));
            end
            wait_idle($sformatf("vec%0d_idle", idx), 200);
            check($sformatf("vec%0d_pending", idx), exp_q.size(), 0);
            check($sformatf("vec%0d_issues", idx), n_issue - base, (v.n == 0) ? 1 : v.n);
            check($sformatf("vec%0d_errs", idx), {err_key, err_timeout}, 2'b00);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        bit seen;

        set_vec(0, 2'b01, 8'd100, 0, 8'd0,   8'd0,   8'd0,  8'd123, 8'd0,   8'd0,   1'b0);
        set_vec(1, 2'b10, 8'd123, 3, 8'd10,  8'd200, 8'd150, 8'd133, 8'd100, 8'd50,  1'b0);
        set_vec(2, 2'b11, 8'd100, 3, 8'd133, 8'd100, 8'd50,  8'd10,  8'd200, 8'd150, 1'b0);
        set_vec(3, 2'b11, 8'd0,   0, 8'd0,   8'd0,   8'd0,  8'd0,   8'd0,   8'd0,   1'b1);
        set_vec(4, 2'b11, 8'd223, 0, 8'd0,   8'd0,   8'd0,  8'd0,   8'd0,   8'd0,   1'b1);
        set_vec(5, 2'b01, 8'd222, 0, 8'd0,   8'd0,   8'd0,  8'd1,   8'd0,   8'd0,   1'b0);
        set_vec(6, 2'b11, 8'd1,   1, 8'd0,   8'd0,   8'd0,  8'd1,   8'd0,   8'd0,   1'b0);
        set_vec(7, 2'b01, 8'd0,   0, 8'd0,   8'd0,   8'd0,  8'd0,   8'd0,   8'd0,   1'b1);
        set_vec(8, 2'b10, 8'd0,   1, 8'd5,   8'd0,   8'd0,  8'd5,   8'd0,   8'd0,   1'b0);

        reset_n = 1'b0; cfg_mode = 2'b00; cfg_key = 8'h00; cfg_start = 1'b0;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("reset_outs", {s_ready, m_valid, m_last, m_data, busy, err_key, err_timeout},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        check("reset_sae", {sae_mode, sae_data, sae_key, sae_valid}, 19'h0);

        // Mode 00 never starts an operation.
        start_op(2'b00, 8'd5);
        check("mode00_ignored", busy, 1'b0);

        for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

        // Decrypt with the FIFO pre-filled to DEPTH; the extra byte starts the next message.
        cur_mode = 2'b11; cur_key = 8'd100;
        exp_q.push_back({1'b0, 8'd10});
        exp_q.push_back({1'b0, 8'd200});
        exp_q.push_back({1'b1, 8'd150});
        feed_byte(8'd133, 1'b0);
        feed_byte(8'd100, 1'b0);
        feed_byte(8'd50, 1'b1);
        feed_byte(8'd77, 1'b1);
        check("full_sready", s_ready, 1'b0);
        start_op(2'b11, 8'd100);
        wait_idle("full_idle", 200);
        check("full_pending", exp_q.size(), 0);
        check("full_leftover_sready", s_ready, 1'b1);
        exp_q.push_back({1'b1, 8'd177});
        start_op(2'b11, 8'd100);
        wait_idle("leftover_idle", 200);
        check("leftover_pending", exp_q.size(), 0);

        // Backpressure: result held stable, no new issue, start while busy ignored.
        cur_mode = 2'b10; cur_key = 8'd123;
        base = n_issue;
        exp_q.push_back({1'b0, 8'd133});
        exp_q.push_back({1'b0, 8'd100});
        exp_q.push_back({1'b1, 8'd50});
        feed_byte(8'd10, 1'b0);
        feed_byte(8'd200, 1'b0);
        feed_byte(8'd150, 1'b1);
        m_ready = 1'b0;
        start_op(2'b10, 8'd123);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!m_valid && cnt < 40);
        check("bp_first_valid", m_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {m_valid, m_last, m_data, sae_valid}, {1'b1, 1'b0, 8'd133, 1'b0});
        end
        start_op(2'b01, 8'd5);
        check("bp_start_ignored", {busy, sae_mode, sae_key}, {1'b1, 2'b10, 8'd123});
        m_ready = 1'b1;
        wait_idle("bp_idle", 200);
        check("bp_pending", exp_q.size(), 0);
        check("bp_issues", n_issue - base, 3);

        // Timeout: mute engine, expect abort after 8 WAIT cycles and a flushed FIFO.
        eng_mute = 1'b1;
        feed_byte(8'd1, 1'b0);
        feed_byte(8'd2, 1'b0);
        feed_byte(8'd3, 1'b1);
        start_op(2'b10, 8'd123);
        wait_sae_valid("to_issue");
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (busy && cnt < 40);
        check("to_cycles", cnt, 2 + TIMEOUT);
        check("to_flags", {err_timeout, err_key, busy, s_ready}, 4'b1001);
        eng_mute = 1'b0;
        start_op(2'b10, 8'd123);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | sae_valid;
        end
        check("to_fifo_empty", {seen, busy}, 2'b01);
        check("to_err_cleared", err_timeout, 1'b0);
        exp_q.push_back({1'b1, 8'd127});
        feed_byte(8'd4, 1'b1);
        wait_idle("to_recover_idle", 200);
        check("to_recover_pending", exp_q.size(), 0);

        // Engine rejects the key during WAIT.
        cur_mode = 2'b11; cur_key = 8'd100;
        base = n_issue;
        eng_err_mode = 1'b1;
        feed_byte(8'd40, 1'b1);
        start_op(2'b11, 8'd100);
        wait_idle("eng_err_idle", 40);
        check("eng_err_flags", {err_key, err_timeout}, 2'b10);
        check("eng_err_issues", n_issue - base, 1);
        eng_err_mode = 1'b0;

        // Reset in the middle of WAIT.
        cur_mode = 2'b10; cur_key = 8'd123;
        eng_mute = 1'b1;
        feed_byte(8'd7, 1'b0);
        feed_byte(8'd8, 1'b1);
        start_op(2'b10, 8'd123);
        wait_sae_valid("rst_issue");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_outs", {s_ready, m_valid, m_last, m_data, busy, err_key, err_timeout},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        check("rst_sae", {sae_mode, sae_data, sae_key, sae_valid}, 19'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        eng_mute = 1'b0;
        start_op(2'b10, 8'd123);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | sae_valid;
        end
        check("rst_fifo_empty", {seen, busy}, 2'b01);
        exp_q.push_back({1'b1, 8'd132});
        feed_byte(8'd9, 1'b1);
        wait_idle("rst_recover_idle", 200);
        check("rst_recover_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
